// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: coin denominations,
// sequencer states, price/change limits and the change clamp helper.
package vend_pkg;

   typedef enum logic [1:0] {
      ONE  = 2'd0,
      TWO  = 2'd1,
      FIVE = 2'd2
   } coin_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      CHECK  = 3'd2,
      VEND   = 3'd3,
      CHANGE = 3'd4
   } seq_state_e;

   localparam int PRICE      = 5;
   localparam int MAX_CHANGE = 4;

   // The hopper never pays back more than MAX_CHANGE cents for one vend.
   function automatic logic [2:0] clamp_change(input logic [2:0] amount);
      return (amount > 3'(MAX_CHANGE)) ? 3'(MAX_CHANGE) : amount;
   endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small circular buffer of pending coin denominations; a push is accepted
// while full when a pop happens in the same cycle.
module coin_fifo
   import vend_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  coin_e         push_data,
   input  logic          pop,
   output coin_e         head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   coin_e         mem_r [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop_s  = pop && (count_r != '0);
   assign do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);

   assign head  = mem_r[rd_ptr_r];
   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == '0);
   assign count = count_r;

   // Storage array; contents are don't-care until the count says otherwise.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

endmodule

// File: rtl/vend_sequencer.sv
// Coin intake, buffering and sequencing toward the vending core, followed by
// motor control and greedy change payout through the hopper.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             coin_one,
   input  logic             coin_two,
   input  logic             coin_five,
   output logic             one,
   output logic             two,
   output logic             five,
   input  logic             d,
   input  logic [2:0]       r,
   output logic             coin_reject,
   output logic             motor_start,
   input  logic             motor_done,
   output logic             pay1,
   output logic             pay2,
   input  logic             hopper_ack,
   output logic             busy,
   output logic [CNT_W-1:0] vend_count
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   seq_state_e    state_r;
   seq_state_e    state_next_s;
   logic [2:0]    change_left_r;
   logic [2:0]    change_next_s;
   coin_e         push_coin_s;
   coin_e         head_s;
   logic          sensed_s;
   logic          extra_s;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic          empty_s;
   logic [CW-1:0] count_s;
   logic          fifo_busy_next_s;

   coin_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_coin_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_coin_s),
      .pop       (pop_s),
      .head      (head_s),
      .full      (full_s),
      .empty     (empty_s),
      .count     (count_s)
   );

   // Coin intake; coin_reject is combinational so it lines up with the sensor pulse.
   always_comb begin
      push_coin_s = ONE;
      sensed_s    = 1'b0;
      extra_s     = 1'b0;
      if (coin_five) begin
         push_coin_s = FIVE;
         sensed_s    = 1'b1;
         extra_s     = coin_two | coin_one;
      end else if (coin_two) begin
         push_coin_s = TWO;
         sensed_s    = 1'b1;
         extra_s     = coin_one;
      end else if (coin_one) begin
         push_coin_s = ONE;
         sensed_s    = 1'b1;
         extra_s     = 1'b0;
      end else begin
         push_coin_s = ONE;
         sensed_s    = 1'b0;
         extra_s     = 1'b0;
      end
      pop_s       = (state_r == IDLE) && !empty_s;
      push_s      = !reset && sensed_s && (!full_s || pop_s);
      coin_reject = !reset && (extra_s || (sensed_s && full_s && !pop_s));
   end

   assign fifo_busy_next_s = ((count_s + CW'(push_s) - CW'(pop_s)) != '0);

   // Next-state and change bookkeeping.
   always_comb begin
      state_next_s  = state_r;
      change_next_s = change_left_r;
      case (state_r)
         IDLE: begin
            if (pop_s) begin
               state_next_s = ISSUE;
            end else begin
               state_next_s = IDLE;
            end
         end
         ISSUE: begin
            state_next_s = CHECK;
         end
         CHECK: begin
            if (d) begin
               state_next_s  = VEND;
               change_next_s = clamp_change(r);
            end else begin
               state_next_s = IDLE;
            end
         end
         VEND: begin
            if (motor_done) begin
               state_next_s = (change_left_r != 3'd0) ? CHANGE : IDLE;
            end else begin
               state_next_s = VEND;
            end
         end
         CHANGE: begin
            if (hopper_ack) begin
               if (change_left_r >= 3'd2) begin
                  change_next_s = change_left_r - 3'd2;
               end else begin
                  change_next_s = 3'd0;
               end
               state_next_s = (change_next_s == 3'd0) ? IDLE : CHANGE;
            end else begin
               state_next_s = CHANGE;
            end
         end
         default: begin
            state_next_s  = IDLE;
            change_next_s = 3'd0;
         end
      endcase
   end

   // State and registered outputs, all derived from the upcoming state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         change_left_r <= 3'd0;
         one           <= 1'b0;
         two           <= 1'b0;
         five          <= 1'b0;
         motor_start   <= 1'b0;
         pay1          <= 1'b0;
         pay2          <= 1'b0;
         busy          <= 1'b0;
         vend_count    <= '0;
      end else begin
         state_r       <= state_next_s;
         change_left_r <= change_next_s;
         one           <= pop_s && (head_s == ONE);
         two           <= pop_s && (head_s == TWO);
         five          <= pop_s && (head_s == FIVE);
         motor_start   <= (state_next_s == VEND);
         pay2          <= (state_next_s == CHANGE) && (change_next_s >= 3'd2);
         pay1          <= (state_next_s == CHANGE) && (change_next_s == 3'd1);
         busy          <= (state_next_s != IDLE) || fifo_busy_next_s;
         if ((state_r == VEND) && motor_done && (vend_count != '1)) begin
            vend_count <= vend_count + 1'b1;
         end
      end
   end

endmodule
